// File: rtl/icache_pkg.sv
// Shared types, parameter defaults and address-field width helpers for the
// instruction-cache fill controller.
package icache_pkg;

    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_LINES      = 8;
    localparam int unsigned DEF_ROM_LAT    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned line_words,
                                          input int unsigned lines);
        return addr_w - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Cache data array: one synchronous write port, one combinational read port,
// deliberately left without reset.
module icache_line_store #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     wren,
    input  logic [$clog2(DEPTH)-1:0] wroffset,
    input  logic [DATA_W-1:0]        wrdata,
    input  logic [$clog2(DEPTH)-1:0] rdoffset,
    output logic [DATA_W-1:0]        rddata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wroffset] <= wrdata;
        end
    end

    always_comb begin
        rddata = mem[rdoffset];
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache controller: tag/valid lookup, line fill
// from a multi-cycle ROM, CPU stall generation and stall-cycle counting.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned LINES      = DEF_LINES,
    parameter int unsigned ROM_LAT    = DEF_ROM_LAT
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [ADDR_W-1:0]                            pm_address,
    input  logic                                         flush,
    input  logic [DATA_W-1:0]                            rom_data,
    output logic [ADDR_W-1:0]                            rom_address,
    output logic [DATA_W-1:0]                            ir,
    output logic                                         hold,
    output logic                                         start_hold,
    output logic                                         end_hold,
    output logic                                         cache_wren,
    output logic [off_w(LINE_WORDS)+idx_w(LINES)-1:0]    cache_wroffset,
    output logic [off_w(LINE_WORDS)+idx_w(LINES)-1:0]    cache_rdoffset,
    output logic [7:0]                                   hold_count
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned IDX_W = idx_w(LINES);
    localparam int unsigned TAG_W = tag_w(ADDR_W, LINE_WORDS, LINES);

    localparam logic [2:0]       LAT_LAST  = 3'(ROM_LAT - 1);
    localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(LINE_WORDS - 1);

    fill_state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  word_q;
    logic [2:0]        lat_q;
    logic              flush_pend_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] rd_word;

    logic [OFF_W-1:0]  pm_off;
    logic [IDX_W-1:0]  pm_idx;
    logic [TAG_W-1:0]  pm_tag;
    logic              hit;

    always_comb begin
        pm_off = pm_address[OFF_W-1:0];
        pm_idx = pm_address[OFF_W +: IDX_W];
        pm_tag = pm_address[ADDR_W-1 -: TAG_W];
        hit    = valid_q[pm_idx] && (tag_mem[pm_idx] == pm_tag);
    end

    assign cache_rdoffset = {pm_idx, pm_off};
    assign cache_wroffset = {idx_q, word_q};

    icache_line_store #(
        .DATA_W (DATA_W),
        .DEPTH  (LINES * LINE_WORDS)
    ) u_line_store (
        .clk      (clk),
        .wren     (cache_wren),
        .wroffset (cache_wroffset),
        .wrdata   (rom_data),
        .rdoffset (cache_rdoffset),
        .rddata   (rd_word)
    );

    always_comb begin
        state_d     = state_q;
        hold        = 1'b0;
        start_hold  = 1'b0;
        end_hold    = 1'b0;
        cache_wren  = 1'b0;
        rom_address = '0;
        ir          = ir_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    ir = rd_word;
                end else begin
                    hold       = 1'b1;
                    start_hold = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                hold        = 1'b1;
                rom_address = {tag_q, idx_q, word_q};
                if (lat_q == LAT_LAST) begin
                    cache_wren = 1'b1;
                    if (word_q == WORD_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                hold     = 1'b1;
                end_hold = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered state is already forced idle in reset; only the
        // address-dependent miss indication needs masking here.
        if (!reset) begin
            hold       = 1'b0;
            start_hold = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            hold_count   <= '0;
            ir_q         <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            lat_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir;

            // The start cycle itself already counts as a stalled cycle.
            if (start_hold) begin
                hold_count <= 8'd1;
            end else if (hold && hold_count != 8'hFF) begin
                hold_count <= hold_count + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        tag_q        <= pm_tag;
                        idx_q        <= pm_idx;
                        word_q       <= '0;
                        lat_q        <= '0;
                        flush_pend_q <= 1'b0;
                    end
                end
                FILL: begin
                    if (lat_q == LAT_LAST) begin
                        lat_q  <= '0;
                        word_q <= word_q + OFF_W'(1);
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!flush && !flush_pend_q) begin
                        valid_q[idx_q] <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == DONE) begin
            tag_mem[idx_q] <= tag_q;
        end
    end

endmodule
